// File: rtl/pe_stream_sequencer_pkg.sv
// Shared types and constants for the PE stream sequencer: FSM state encoding,
// source-select codes and default group sizes.
package pe_stream_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_O   = 3'd2,
    STREAM_I = 3'd3,
    DRAIN_O  = 3'd4,
    DONE     = 3'd5
  } state_e;

  localparam logic [1:0] SEL_W    = 2'd0;
  localparam logic [1:0] SEL_O    = 2'd1;
  localparam logic [1:0] SEL_I    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam int W_PE_GROUP_SIZE = 4;
  localparam int O_PE_GROUP_SIZE = 4;
  localparam int I_PE_GROUP_SIZE = W_PE_GROUP_SIZE + O_PE_GROUP_SIZE - 1;
  localparam int I_BLOCK_COUNT   = 4;

endpackage

// File: rtl/pe_stream_sequencer_beat_counter.sv
// Up-counter that wraps to zero on the enabled cycle where it sits at last_i;
// term_o flags that the current value is the terminal one.
module pe_beat_counter #(
  parameter int Width = 3
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] last_i,
  output logic             term_o
);

  logic [Width-1:0] count_q;
  logic [Width-1:0] count_d;

  assign term_o = (count_q == last_i);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = term_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_stream_sequencer.sv
// Control sequencer for the PE address controller: one start pulse loads the
// weights once, then runs I_BlockCount blocks of partial-sum load, input stream and drain.
module pe_stream_sequencer
  import pe_stream_sequencer_pkg::*;
#(
  parameter int W_PEGroupSize = W_PE_GROUP_SIZE,
  parameter int O_PEGroupSize = O_PE_GROUP_SIZE,
  parameter int I_BlockCount  = I_BLOCK_COUNT,
  parameter int CntWidth      = 3,
  parameter int BlkWidth      = 2
) (
  input  logic       clk,
  input  logic       sclr,
  input  logic       start,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [1:0] src_sel,
  input  logic       out_ready,
  output logic       EN_W,
  output logic       EN_O_In,
  output logic       EN_I,
  output logic       EN_O_Out,
  output logic       busy,
  output logic       done
);

  localparam int I_PEGroupSize = W_PEGroupSize + O_PEGroupSize - 1;

  state_e state_q;
  state_e state_d;

  logic [CntWidth-1:0] beatLast;
  logic                beatTerm;
  logic                blkTerm;
  logic                beatEn;
  logic                blkEn;
  logic                passStart;

  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    src_sel   = SEL_NONE;
    EN_W      = 1'b0;
    EN_O_In   = 1'b0;
    EN_I      = 1'b0;
    EN_O_Out  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    beatLast  = '0;
    blkEn     = 1'b0;
    passStart = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        passStart = start;
        if (start) state_d = LOAD_W;
      end
      LOAD_W: begin
        src_ready = 1'b1;
        src_sel   = SEL_W;
        EN_W      = src_valid;
        beatLast  = CntWidth'(W_PEGroupSize - 1);
        if (EN_W && beatTerm) state_d = LOAD_O;
      end
      LOAD_O: begin
        src_ready = 1'b1;
        src_sel   = SEL_O;
        EN_O_In   = src_valid;
        beatLast  = CntWidth'(O_PEGroupSize - 1);
        if (EN_O_In && beatTerm) state_d = STREAM_I;
      end
      STREAM_I: begin
        src_ready = 1'b1;
        src_sel   = SEL_I;
        EN_I      = src_valid;
        beatLast  = CntWidth'(I_PEGroupSize - 1);
        if (EN_I && beatTerm) state_d = DRAIN_O;
      end
      DRAIN_O: begin
        EN_O_Out = out_ready;
        beatLast = CntWidth'(O_PEGroupSize - 1);
        // The block counter steps on the last drain beat and self-clears after the final block.
        if (EN_O_Out && beatTerm) begin
          blkEn   = 1'b1;
          state_d = blkTerm ? DONE : LOAD_O;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beatEn = EN_W | EN_O_In | EN_I | EN_O_Out;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  pe_beat_counter #(.Width(CntWidth)) u_beat_cnt (
    .clk    (clk),
    .sclr   (sclr),
    .en_i   (beatEn),
    .clr_i  (passStart),
    .last_i (beatLast),
    .term_o (beatTerm)
  );

  pe_beat_counter #(.Width(BlkWidth)) u_blk_cnt (
    .clk    (clk),
    .sclr   (sclr),
    .en_i   (blkEn),
    .clr_i  (passStart),
    .last_i (BlkWidth'(I_BlockCount - 1)),
    .term_o (blkTerm)
  );

endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Scoreboard bench: each accepted start queues the ordered list of strobe events a pass
// must produce; a negedge monitor checks every cycle's outputs against the queue head.
module tb_pe_stream_sequencer;

  typedef enum int {EV_W, EV_OIN, EV_I, EV_OOUT, EV_DONE} ev_e;

  localparam int EVT_NONE      = 0;
  localparam int EVT_BACKPRESS = 1;
  localparam int EVT_RESET     = 2;
  localparam int EVT_STARTBUSY = 3;

  logic       clk;
  logic       sclr;
  logic       start;
  logic       src_valid;
  logic       src_ready;
  logic [1:0] src_sel;
  logic       out_ready;
  logic       EN_W;
  logic       EN_O_In;
  logic       EN_I;
  logic       EN_O_Out;
  logic       busy;
  logic       done;

  ev_e expQ[$];
  int  totalChecks = 0;
  int  badChecks   = 0;
  int  cycleCount  = 0;
  int  passStart   = 0;
  int  iPopped     = 0;
  int  nW = 0, nOIn = 0, nI = 0, nOOut = 0;
  bit  monitorOn   = 0;
  bit  checkLatency = 0;

  pe_stream_sequencer dut (
    .clk       (clk),
    .sclr      (sclr),
    .start     (start),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_sel   (src_sel),
    .out_ready (out_ready),
    .EN_W      (EN_W),
    .EN_O_In   (EN_O_In),
    .EN_I      (EN_I),
    .EN_O_Out  (EN_O_Out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    totalChecks++;
    if (act !== expv) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycleCount);
    end
  endtask

  // A pass is 4 weight beats, then per block 4 psum-in, 7 input and 4 drain beats, then done.
  task automatic pushPass();
    repeat (4) expQ.push_back(EV_W);
    for (int b = 0; b < 4; b++) begin
      repeat (4) expQ.push_back(EV_OIN);
      repeat (7) expQ.push_back(EV_I);
      repeat (4) expQ.push_back(EV_OOUT);
    end
    expQ.push_back(EV_DONE);
    iPopped = 0;
    nW = 0; nOIn = 0; nI = 0; nOOut = 0;
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] expv;
    bit         fire;
    ev_e        f;
    if (monitorOn) begin
      act  = {busy, done, src_ready, src_sel, EN_W, EN_O_In, EN_I, EN_O_Out};
      expv = {1'b0, 1'b0, 1'b0, 2'd3, 4'b0000};
      fire = 1'b0;
      f    = EV_DONE;
      if (expQ.size() != 0) begin
        f = expQ[0];
        case (f)
          EV_W:    begin expv = {3'b101, 2'd0, src_valid, 3'b000};        fire = src_valid; end
          EV_OIN:  begin expv = {3'b101, 2'd1, 1'b0, src_valid, 2'b00};   fire = src_valid; end
          EV_I:    begin expv = {3'b101, 2'd2, 2'b00, src_valid, 1'b0};   fire = src_valid; end
          EV_OOUT: begin expv = {3'b100, 2'd3, 3'b000, out_ready};        fire = out_ready; end
          default: begin expv = {3'b110, 2'd3, 4'b0000};                  fire = 1'b1; end
        endcase
      end
      checkOutput("outputs", 32'(act), 32'(expv));

      totalChecks++;
      assert (($countones({EN_W, EN_O_In, EN_I, EN_O_Out}) <= 1) && !(src_sel == 2'd3 && src_ready))
      else begin
        badChecks++;
        $display("[TB] FAIL exclusion: en=%b sel=%0d ready=%b", {EN_W, EN_O_In, EN_I, EN_O_Out}, src_sel, src_ready);
      end

      nW    += int'(EN_W);
      nOIn  += int'(EN_O_In);
      nI    += int'(EN_I);
      nOOut += int'(EN_O_Out);

      if (fire) begin
        void'(expQ.pop_front());
        if (f == EV_I) iPopped++;
        if (f == EV_DONE) begin
          checkOutput("totals", {8'(nW), 8'(nOIn), 8'(nI), 8'(nOOut)}, {8'd4, 8'd16, 8'd28, 8'd16});
          if (checkLatency) checkOutput("latency", 32'(cycleCount - passStart), 32'd65);
        end
      end
    end
  end

  task automatic pulseStart();
    bit wasIdle;
    wasIdle   = (expQ.size() == 0);
    passStart = cycleCount;
    start     = 1'b1;
    @(posedge clk);
    if (wasIdle) pushPass();
    #1 start = 1'b0;
  endtask

  function automatic logic pick(input int mode, input bit toggle);
    if (mode == 0) return 1'b1;
    if (mode == 1) return toggle;
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic applyStimulus(input int validMode, input int readyMode, input int evt, input bit latency);
    int holdCnt;
    bit evtDone;
    bit toggle;
    holdCnt = 0;
    evtDone = 0;
    toggle  = 1'b1;
    checkLatency = latency;
    src_valid = 1'b1;
    out_ready = 1'b1;
    pulseStart();
    for (int c = 0; c < 3000 && expQ.size() != 0; c++) begin
      src_valid = pick(validMode, toggle);
      out_ready = pick(readyMode, toggle);
      toggle = ~toggle;
      if (evt == EVT_BACKPRESS && !evtDone && expQ[0] == EV_OOUT && iPopped == 21) begin
        holdCnt = 10;
        evtDone = 1;
      end
      if (holdCnt > 0) begin
        out_ready = 1'b0;
        holdCnt--;
      end
      if (evt == EVT_RESET && !evtDone && expQ[0] == EV_I && iPopped == 10) begin
        sclr = 1'b1;
        evtDone = 1;
      end
      if (evt == EVT_STARTBUSY && !evtDone && expQ[0] == EV_OIN && iPopped == 0) begin
        start = 1'b1;
        evtDone = 1;
      end
      @(posedge clk);
      if (sclr) expQ.delete();
      #1;
      sclr  = 1'b0;
      start = 1'b0;
    end
    checkOutput("timeout", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    sclr      = 1'b1;
    start     = 1'b0;
    src_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 monitorOn = 1'b1;
    @(posedge clk);
    #1 sclr = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] full pass, no stalls");
    applyStimulus(0, 0, EVT_NONE, 1'b1);
    $display("[TB] source stalls");
    applyStimulus(1, 0, EVT_NONE, 1'b0);
    $display("[TB] drain backpressure");
    applyStimulus(0, 0, EVT_BACKPRESS, 1'b0);
    $display("[TB] reset mid-pass then restart");
    applyStimulus(0, 0, EVT_RESET, 1'b0);
    applyStimulus(0, 0, EVT_NONE, 1'b0);
    $display("[TB] start while busy");
    applyStimulus(0, 0, EVT_STARTBUSY, 1'b1);
    $display("[TB] random handshakes");
    for (int r = 0; r < 3; r++) applyStimulus(2, 2, EVT_NONE, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
